// File: rtl/decoder3_pkg.sv
// Shared types and widths for the held 3-to-8 decoder.
// The one-hot decode helper is used by the top-level datapath.
package decoder3_pkg;

    localparam int CODE_W  = 3;
    localparam int LINES_W = 8;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        SPACE = 2'd2
    } state_e;

    function automatic logic [LINES_W-1:0] decode(input logic [CODE_W-1:0] i_code);
        return LINES_W'(1) << i_code;
    endfunction

endpackage

// File: rtl/hold_counter.sv
// Loadable down-counter that parks at zero instead of wrapping.
// Load takes priority over enable.
module hold_counter
    import decoder3_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/decoder3_hold.sv
// 3-to-8 decoder that holds the decoded line for HOLD cycles, then idles
// for GAP cycles before accepting the next code word.
module decoder3_hold
    import decoder3_pkg::*;
#(
    parameter int unsigned HOLD = 4,
    parameter int unsigned GAP  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               none_on,
    input  logic [CODE_W-1:0]  code,
    output logic [LINES_W-1:0] lines,
    output logic               active,
    output logic               done
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

    state_e             r_state;
    state_e             w_state_next;
    logic [LINES_W-1:0] r_lines;
    logic [LINES_W-1:0] w_lines_next;
    logic               r_done;
    logic               w_done_next;
    logic               w_xfer;
    logic               w_load;
    logic [CNT_W-1:0]   w_load_val;
    logic               w_en;
    logic [CNT_W-1:0]   w_count;
    logic               w_zero;

    hold_counter u_hold_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (w_en),
        .o_count    (w_count),
        .o_zero     (w_zero)
    );

    assign w_xfer = in_valid && (r_state == IDLE);

    // NOTE: the whole register set, outputs included, is cleared by the async
    // reset so an interrupted drive leaves no stale line or done pulse behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_lines_next = r_lines;
        w_done_next  = 1'b0;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_en         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer && !none_on) begin
                    w_state_next = DRIVE;
                    w_lines_next = decode(code);
                    w_load       = 1'b1;
                    w_load_val   = HOLD_LOAD;
                    w_done_next  = (HOLD == 1);
                end
            end
            DRIVE: begin
                if (w_zero) begin
                    w_lines_next = '0;
                    if (GAP > 0) begin
                        w_state_next = SPACE;
                        w_load       = 1'b1;
                        w_load_val   = GAP_LOAD;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_en        = 1'b1;
                    // Count reaches zero next cycle: that cycle is the last drive cycle.
                    w_done_next = (w_count == CNT_W'(1));
                end
            end
            SPACE: begin
                if (w_zero) begin
                    w_state_next = IDLE;
                end else begin
                    w_en = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_lines_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lines <= '0;
            r_done  <= 1'b0;
        end else begin
            r_lines <= w_lines_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        in_ready = (r_state == IDLE);
        active   = |r_lines;
    end

    assign lines = r_lines;
    assign done  = r_done;

endmodule

// File: tb/tb_decoder3_hold.sv
// Scoreboard bench for decoder3_hold: default instance (HOLD=4, GAP=1) against
// a busy-count reference model, plus a HOLD=1/GAP=0 instance driven directly.
module tb_decoder3_hold;

    localparam int HOLD = 4;
    localparam int GAP  = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, none_on;
    logic [2:0] code;
    logic       in_ready, active, done;
    logic [7:0] lines;

    logic       in_valid_b, none_on_b;
    logic [2:0] code_b;
    logic       in_ready_b, active_b, done_b;
    logic [7:0] lines_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state: cycles remaining until the block is ready again.
    int         busy    = 0;
    int         m_xfers = 0;
    logic [7:0] exp_q[$];

    int dut_xfers = 0;
    int dut_xfer_cyc[$];

    always #5 clk = ~clk;

    decoder3_hold #(.HOLD(HOLD), .GAP(GAP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .none_on  (none_on),
        .code     (code),
        .lines    (lines),
        .active   (active),
        .done     (done)
    );

    decoder3_hold #(.HOLD(1), .GAP(0)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid_b),
        .in_ready (in_ready_b),
        .none_on  (none_on_b),
        .code     (code_b),
        .lines    (lines_b),
        .active   (active_b),
        .done     (done_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Model: a drive occupies HOLD+GAP cycles after the accepting edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy = 0;
            exp_q.delete();
        end else if (busy > 0) begin
            busy--;
        end else if (in_valid) begin
            m_xfers++;
            if (!none_on) begin
                busy = HOLD + GAP;
                exp_q.push_back(8'(32'd1 << code));
            end
        end
    end

    // Monitor: compares every cycle away from the active edge, pops at done.
    always @(negedge clk) begin
        check("ready", in_ready, busy == 0);
        check("active_or", active, |lines);
        check("onehot", $countones(lines) <= 1, 1);
        check("drive", active, busy > GAP);
        check("done", done, busy == GAP + 1);
        if (busy > GAP) begin
            check("lines", lines, (exp_q.size() != 0) ? exp_q[0] : 8'h00);
            if (busy == GAP + 1 && exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (in_valid && in_ready) begin
            dut_xfers++;
            dut_xfer_cyc.push_back(cyc);
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic nv, input logic [2:0] c, input logic keep);
        int n0;
        n0       = dut_xfers;
        none_on  = nv;
        code     = c;
        in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            sync();
            if (dut_xfers != n0) break;
        end
        check("xfer_seen", dut_xfers - n0, 1);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        repeat (HOLD + GAP + 2) sync();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        rst_n = 1'b0;
        in_valid = 1'b0; none_on = 1'b0; code = 3'd0;
        in_valid_b = 1'b0; none_on_b = 1'b0; code_b = 3'd0;
        #1;
        check("rst_lines", lines, 8'h00);
        check("rst_active", active, 0);
        check("rst_done", done, 0);
        check("rst_ready", in_ready, 1);
        check("rst_lines_b", lines_b, 8'h00);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        sync();

        // code=5: four drive cycles, done in the fourth, one space cycle.
        send(1'b0, 3'd5, 1'b0);
        for (int i = 0; i < HOLD; i++) begin
            @(negedge clk);
            check("c5_lines", lines, 8'h20);
            check("c5_done", done, i == HOLD - 1);
        end
        @(negedge clk);
        check("c5_space_lines", lines, 8'h00);
        check("c5_space_ready", in_ready, 0);
        @(negedge clk);
        check("c5_ready", in_ready, 1);
        sync();

        // none_on word is swallowed; next word accepted the very next cycle.
        dut_xfer_cyc.delete();
        send(1'b1, 3'd3, 1'b0);
        check("none_ready", in_ready, 1);
        check("none_lines", lines, 8'h00);
        send(1'b0, 3'd0, 1'b0);
        check("none_cnt", dut_xfer_cyc.size(), 2);
        if (dut_xfer_cyc.size() == 2)
            check("none_spacing", dut_xfer_cyc[1] - dut_xfer_cyc[0], 1);
        @(negedge clk);
        check("c0_lines", lines, 8'h01);
        wait_idle();

        // Valid held high across three words: back-to-back at 1+HOLD+GAP.
        dut_xfer_cyc.delete();
        send(1'b0, 3'd7, 1'b1);
        send(1'b0, 3'd0, 1'b1);
        send(1'b0, 3'd7, 1'b0);
        check("b2b_cnt", dut_xfer_cyc.size(), 3);
        if (dut_xfer_cyc.size() == 3) begin
            check("b2b_gap0", dut_xfer_cyc[1] - dut_xfer_cyc[0], 1 + HOLD + GAP);
            check("b2b_gap1", dut_xfer_cyc[2] - dut_xfer_cyc[1], 1 + HOLD + GAP);
        end
        wait_idle();

        // Code churn during DRIVE is ignored.
        send(1'b0, 3'd1, 1'b0);
        n0 = dut_xfers;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            none_on  = 1'b0;
            code     = 3'($urandom);
            sync();
            check("churn_lines", lines, 8'h02);
        end
        in_valid = 1'b0;
        check("churn_xfers", dut_xfers - n0, 0);
        wait_idle();

        // Async reset in the second drive cycle of code=2.
        send(1'b0, 3'd2, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_lines", lines, 8'h00);
        check("arst_active", active, 0);
        check("arst_done", done, 0);
        check("arst_ready", in_ready, 1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("rel_ready", in_ready, 1);
        sync();

        // HOLD=1, GAP=0 instance.
        in_valid_b = 1'b1; none_on_b = 1'b0; code_b = 3'd6;
        @(negedge clk);
        check("h1_ready0", in_ready_b, 1);
        sync();
        in_valid_b = 1'b0;
        @(negedge clk);
        check("h1_lines", lines_b, 8'h40);
        check("h1_done", done_b, 1);
        check("h1_active", active_b, 1);
        check("h1_busy", in_ready_b, 0);
        @(negedge clk);
        check("h1_after_lines", lines_b, 8'h00);
        check("h1_after_done", done_b, 0);
        check("h1_after_ready", in_ready_b, 1);
        sync();
        in_valid_b = 1'b1; code_b = 3'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("h1_b2b_lines", lines_b, (i % 2 == 1) ? 8'h08 : 8'h00);
            check("h1_b2b_done", done_b, i % 2 == 1);
            check("h1_b2b_ready", in_ready_b, i % 2 == 0);
        end
        sync();
        in_valid_b = 1'b0;

        // Randomized traffic against the model.
        repeat (150) begin
            repeat ($urandom_range(0, 3)) sync();
            send($urandom_range(0, 3) == 0, 3'($urandom), 1'b0);
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decoder3_hold.md
DECODER3_HOLD -- requirements
Module: decoder3_hold

Interface
REQ-001 The block SHALL provide parameter HOLD, default 4: the number of cycles a decoded line is driven, legal range 1..255.
REQ-002 The block SHALL provide parameter GAP, default 1: the number of idle cycles after each drive before the next accept, legal range 0..255.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: the code word on none_on/code is valid.
REQ-006 Port in_ready, output, 1 bit: the block can accept a code word this cycle.
REQ-007 Port none_on, input, 1 bit: no input line was active; the code is ignored.
REQ-008 Port code, input, 3 bits: binary index of the line to assert; 7 selects line h and 0 selects line a.
REQ-009 Port lines, output, 8 bits: one-hot decoded lines; bit 7 is h and bit 0 is a.
REQ-010 Port active, output, 1 bit: high while lines is non-zero.
REQ-011 Port done, output, 1 bit: one-cycle pulse in the last drive cycle.

Function
REQ-012 The block SHALL use states IDLE, DRIVE and SPACE, held in a registered state machine.
REQ-013 In IDLE, in_ready SHALL be 1; in DRIVE and SPACE, in_ready SHALL be 0; in_ready SHALL be decoded from registered state only, with no combinational path from in_valid.
REQ-014 A transfer SHALL occur on any rising edge where in_valid=1 and in_ready=1.
REQ-015 A transfer with none_on=1 SHALL leave the state in IDLE and lines at 0; the word is consumed and discarded.
REQ-016 A transfer with none_on=0 SHALL register lines = 1<<code, set the counter to HOLD-1 and enter DRIVE at that same edge, so the line is visible in the cycle after the transfer (latency 1).
REQ-017 In DRIVE, lines SHALL stay constant for exactly HOLD cycles, and the counter SHALL decrement once per cycle.
REQ-018 done SHALL be 1 only in the DRIVE cycle where the counter is 0.
REQ-019 At the end of DRIVE, lines SHALL go to 0 and the state SHALL become SPACE with the counter at GAP-1; if GAP=0, the state SHALL go directly to IDLE.
REQ-020 SPACE SHALL last exactly GAP cycles, then the state SHALL return to IDLE.
REQ-021 The minimum spacing between consecutive transfers SHALL therefore be 1+HOLD+GAP cycles.
REQ-022 At most one bit of lines SHALL be set in any cycle.
REQ-023 active SHALL equal the OR of lines.
REQ-024 in_valid and code SHALL be ignored outside IDLE; a word presented then SHALL be held by the sender under standard valid/ready rules.
REQ-025 When HOLD=1, done SHALL assert in the first and only DRIVE cycle.
REQ-026 The counter SHALL be 8 bits and SHALL never wrap, because it is reloaded before reaching 0-1.

Reset
REQ-027 While rst_n=0, the block SHALL immediately drive state=IDLE, lines=0, counter=0, done=0 and active=0, independent of clk.
REQ-028 When rst_n is asserted mid-DRIVE or mid-SPACE, the in-progress drive SHALL be abandoned with no done pulse.
REQ-029 in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-030 Deassertion of rst_n SHALL be synchronised externally; the block adds no synchroniser.

Structure
REQ-031 Package decoder3_pkg SHALL hold the state enum (IDLE, DRIVE, SPACE), the constant CODE_W=3, LINES_W=8 and CNT_W=8.
REQ-032 One sub-module, hold_counter, SHALL be used: a loadable 8-bit down-counter with load, load value, enable and a zero flag.
REQ-033 All outputs SHALL come directly from registers, except in_ready and active, which are decoded from registered state.

Verification
REQ-034 Reset then transfer code=5, none_on=0 (HOLD=4, GAP=1) -> lines=8'h20 for 4 cycles starting the cycle after the transfer, done in the 4th cycle, 1 SPACE cycle, then in_ready=1.
REQ-035 Transfer none_on=1, code=3 -> lines stays 0, in_ready stays 1, and a following code=0 transfer is accepted the next cycle with lines=8'h01.
REQ-036 Hold in_valid=1 continuously with codes 7, 0, 7 -> transfers exactly every 6 cycles (1+HOLD+GAP), lines sequence 8'h80, 8'h01, 8'h80, never two bits set.
REQ-037 Assert rst_n=0 in the 2nd DRIVE cycle of code=2 -> lines=0 without waiting for clk, no done pulse, in_ready=1 in the first cycle after release.
REQ-038 With HOLD=1, GAP=0, transfer code=6 -> lines=8'h40 for one cycle with done=1 in that cycle, and in_ready=1 in the next cycle.
REQ-039 Change code while in DRIVE -> lines unchanged and no transfer counted.
